// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC time-edit path: FSM states, field selects,
// register addresses and the field wrap helpers.
package rtc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EDIT,
    ST_WR_SEC,
    ST_GAP_MIN,
    ST_WR_MIN,
    ST_GAP_HR,
    ST_WR_HR,
    ST_FIN
  } state_t;

  typedef enum logic [1:0] {
    FIELD_SEC = 2'd0,
    FIELD_MIN = 2'd1,
    FIELD_HR  = 2'd2
  } field_t;

  localparam logic [7:0] RTC_SEC_ADDR = 8'h21;
  localparam logic [7:0] RTC_MIN_ADDR = 8'h22;
  localparam logic [7:0] RTC_HR_ADDR  = 8'h23;

  localparam logic [5:0] MAX_SEC = 6'd59;
  localparam logic [4:0] MAX_HR  = 5'd23;

  // One up/down step with wrap at both ends of 0..max_v.
  function automatic logic [5:0] wrap_step(input logic [5:0] v,
                                           input logic [5:0] max_v,
                                           input logic       up);
    if (up) return (v == max_v) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0)  ? max_v : v - 6'd1;
  endfunction

  function automatic field_t next_field(input field_t f);
    unique case (f)
      FIELD_SEC: return FIELD_MIN;
      FIELD_MIN: return FIELD_HR;
      default:   return FIELD_SEC;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd6.sv
// Combinational 6-bit binary (0..63) to packed two-digit BCD {tens, ones}.
module bin2bcd6 (
  input  logic [5:0] bin,
  output logic [7:0] bcd
);

  logic [3:0] tens;
  logic [3:0] base_lo;

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    tens    = 4'd0;
    base_lo = 4'd0;
    if (bin >= 6'd60) begin
      tens = 4'd6; base_lo = 4'hC;
    end else if (bin >= 6'd50) begin
      tens = 4'd5; base_lo = 4'h2;
    end else if (bin >= 6'd40) begin
      tens = 4'd4; base_lo = 4'h8;
    end else if (bin >= 6'd30) begin
      tens = 4'd3; base_lo = 4'hE;
    end else if (bin >= 6'd20) begin
      tens = 4'd2; base_lo = 4'h4;
    end else if (bin >= 6'd10) begin
      tens = 4'd1; base_lo = 4'hA;
    end
  end

  // ones = bin - 10*tens always lies in 0..9, so the low nibbles of the
  // operands (base_lo = low nibble of 10*tens) yield it exactly modulo 16.
  assign bcd = {tens, bin[3:0] - base_lo};

endmodule

// File: rtl/time_set_ctrl.sv
// Time-edit controller: captures the running time, lets the user step one field
// at a time, then commits sec/min/hr to the RTC as packed BCD over req/ack.
module time_set_ctrl
  import rtc_pkg::*;
#(
  parameter logic [7:0] SEC_ADDR = RTC_SEC_ADDR,
  parameter logic [7:0] MIN_ADDR = RTC_MIN_ADDR,
  parameter logic [7:0] HR_ADDR  = RTC_HR_ADDR
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_edit,
  input  logic       btn_next,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [5:0] cur_sec,
  input  logic [5:0] cur_min,
  input  logic [4:0] cur_hr,
  input  logic       wr_ack,
  output logic       edit_active,
  output logic [1:0] field_sel,
  output logic [5:0] edit_sec,
  output logic [5:0] edit_min,
  output logic [4:0] edit_hr,
  output logic       wr_req,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       done
);

  state_t     state;
  field_t     sel;
  logic [5:0] bcd_in;
  logic [7:0] bcd;

  assign field_sel = sel;

  // The converter sees the field about to be written on the next edge.
  always_comb begin
    bcd_in = edit_sec;
    unique case (state)
      ST_GAP_MIN: bcd_in = edit_min;
      ST_GAP_HR:  bcd_in = {1'b0, edit_hr};
      default:    bcd_in = edit_sec;
    endcase
  end

  bin2bcd6 u_bin2bcd6 (
    .bin (bcd_in),
    .bcd (bcd)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      sel         <= FIELD_SEC;
      edit_active <= 1'b0;
      edit_sec    <= '0;
      edit_min    <= '0;
      edit_hr     <= '0;
      wr_req      <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (btn_edit) begin
            edit_sec    <= cur_sec;
            edit_min    <= cur_min;
            edit_hr     <= cur_hr;
            sel         <= FIELD_SEC;
            edit_active <= 1'b1;
            state       <= ST_EDIT;
          end
        end

        ST_EDIT: begin
          if (btn_edit) begin
            wr_req  <= 1'b1;
            wr_addr <= SEC_ADDR;
            wr_data <= bcd;
            state   <= ST_WR_SEC;
          end else if (btn_next) begin
            sel <= next_field(sel);
          end else if (btn_up ^ btn_down) begin
            unique case (sel)
              FIELD_SEC: edit_sec <= wrap_step(edit_sec, MAX_SEC, btn_up);
              FIELD_MIN: edit_min <= wrap_step(edit_min, MAX_SEC, btn_up);
              FIELD_HR:  edit_hr  <= 5'(wrap_step({1'b0, edit_hr}, {1'b0, MAX_HR}, btn_up));
              default:   sel      <= FIELD_SEC;
            endcase
          end
        end

        ST_WR_SEC: begin
          if (wr_ack) begin
            wr_req <= 1'b0;
            state  <= ST_GAP_MIN;
          end
        end

        ST_GAP_MIN: begin
          wr_req  <= 1'b1;
          wr_addr <= MIN_ADDR;
          wr_data <= bcd;
          state   <= ST_WR_MIN;
        end

        ST_WR_MIN: begin
          if (wr_ack) begin
            wr_req <= 1'b0;
            state  <= ST_GAP_HR;
          end
        end

        ST_GAP_HR: begin
          wr_req  <= 1'b1;
          wr_addr <= HR_ADDR;
          wr_data <= bcd;
          state   <= ST_WR_HR;
        end

        ST_WR_HR: begin
          if (wr_ack) begin
            wr_req <= 1'b0;
            done   <= 1'b1;
            state  <= ST_FIN;
          end
        end

        ST_FIN: begin
          edit_active <= 1'b0;
          state       <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Randomized bench for time_set_ctrl with a transaction-level reference model
// and a protocol monitor on the RTC write port.
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       reset, btn_edit, btn_next, btn_up, btn_down, wr_ack;
  logic [5:0] cur_sec, cur_min;
  logic [4:0] cur_hr;
  logic       edit_active, wr_req, done;
  logic [1:0] field_sel;
  logic [5:0] edit_sec, edit_min;
  logic [4:0] edit_hr;
  logic [7:0] wr_addr, wr_data;

  always #5 clk = ~clk;

  time_set_ctrl dut (
    .clk(clk), .reset(reset),
    .btn_edit(btn_edit), .btn_next(btn_next), .btn_up(btn_up), .btn_down(btn_down),
    .cur_sec(cur_sec), .cur_min(cur_min), .cur_hr(cur_hr), .wr_ack(wr_ack),
    .edit_active(edit_active), .field_sel(field_sel),
    .edit_sec(edit_sec), .edit_min(edit_min), .edit_hr(edit_hr),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .done(done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // Reference model state: what the user sees and what the RTC should receive.
  typedef struct { int addr; int data; } wr_t;
  wr_t exp_q[$];
  bit  m_act, m_com;
  int  m_sec, m_min, m_hr, m_sel, m_start, m_delay;
  int  cyc = 0, ack_delay = 0, age = 0, n_done = 0;
  bit  prev_req = 1'b0;
  logic [7:0] held_addr, held_data;

  function automatic int to_bcd(input int v);
    return ((v / 10) << 4) | (v % 10);
  endfunction

  task automatic model_step();
    if (reset) begin
      m_act = 0; m_com = 0;
      m_sec = 0; m_min = 0; m_hr = 0; m_sel = 0;
      exp_q.delete();
    end else if (!m_act) begin
      if (btn_edit) begin
        m_sec = cur_sec; m_min = cur_min; m_hr = cur_hr;
        m_sel = 0; m_act = 1;
      end
    end else if (!m_com) begin
      if (btn_edit) begin
        m_com = 1; m_start = cyc; m_delay = ack_delay;
        exp_q.push_back('{32'h21, to_bcd(m_sec)});
        exp_q.push_back('{32'h22, to_bcd(m_min)});
        exp_q.push_back('{32'h23, to_bcd(m_hr)});
      end else if (btn_next) begin
        m_sel = (m_sel + 1) % 3;
      end else if (btn_up != btn_down) begin
        int lim = (m_sel == 2) ? 24 : 60;
        int d   = btn_up ? 1 : lim - 1;
        case (m_sel)
          0: m_sec = (m_sec + d) % lim;
          1: m_min = (m_min + d) % lim;
          default: m_hr = (m_hr + d) % lim;
        endcase
      end
    end else if (cyc - m_start == 3 * (m_delay + 2)) begin
      check("wr_all_seen", exp_q.size(), 0);
      m_act = 0; m_com = 0;
    end
  endtask

  // One clock: model advances at the edge, outputs are compared at the negedge,
  // then the RTC responder decides wr_ack for the next edge.
  task automatic tick();
    bit was_reset;
    int p, o;
    bit exp_req, exp_done;
    @(posedge clk);
    cyc++;
    was_reset = reset;
    model_step();
    @(negedge clk);
    p = m_delay + 2;
    o = cyc - m_start;
    exp_req  = m_com && (o < 3 * p) && ((o % p) <= m_delay);
    exp_done = m_com && (o == 3 * p - 1);
    check("edit_active", edit_active, m_act);
    check("field_sel",   field_sel,   m_sel);
    check("edit_sec",    edit_sec,    m_sec);
    check("edit_min",    edit_min,    m_min);
    check("edit_hr",     edit_hr,     m_hr);
    check("wr_req",      wr_req,      exp_req);
    check("done",        done,        exp_done);
    if (done) n_done++;
    if (was_reset) begin
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_data", wr_data, 0);
    end
    if (wr_req) begin
      if (!prev_req) begin
        if (exp_q.size() == 0) begin
          check("wr_extra_req", wr_req, 0);
        end else begin
          wr_t e = exp_q.pop_front();
          check("wr_addr", wr_addr, e.addr);
          check("wr_data", wr_data, e.data);
        end
        held_addr = wr_addr;
        held_data = wr_data;
      end else begin
        check("wr_addr_hold", wr_addr, held_addr);
        check("wr_data_hold", wr_data, held_data);
      end
      age++;
      wr_ack = (age > m_delay);
    end else begin
      age = 0;
      wr_ack = ($urandom_range(0, 3) == 0);
    end
    prev_req = wr_req;
  endtask

  task automatic step(input bit e, input bit n, input bit u, input bit d);
    btn_edit = e; btn_next = n; btn_up = u; btn_down = d;
    tick();
    btn_edit = 0; btn_next = 0; btn_up = 0; btn_down = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic set_cur(input int h, input int m, input int s);
    cur_hr = 5'(h); cur_min = 6'(m); cur_sec = 6'(s);
  endtask

  initial begin
    int d0;
    reset = 1'b1; wr_ack = 1'b0;
    btn_edit = 0; btn_next = 0; btn_up = 0; btn_down = 0;
    set_cur(0, 0, 0);
    m_start = 0; m_delay = 0;
    tick();
    do_reset();
    check("rst_active", edit_active, 0);

    // Seconds wrap without carrying into minutes.
    set_cur(12, 58, 59);
    step(1, 0, 0, 0);
    set_cur(1, 2, 3);
    step(0, 0, 1, 0);
    check("t2_sec", edit_sec, 0);
    check("t2_min", edit_min, 58);

    // Hours wrap downward, field select wraps back to seconds.
    do_reset();
    set_cur(0, 30, 10);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    check("t3_sel_hr", field_sel, 2);
    step(0, 0, 0, 1);
    check("t3_hr", edit_hr, 23);
    step(0, 1, 0, 0);
    check("t3_sel_wrap", field_sel, 0);

    // Simultaneous buttons.
    step(0, 0, 1, 1);
    check("t4_updown", edit_sec, 10);
    step(0, 1, 1, 0);
    check("t4_next_sel", field_sel, 1);
    check("t4_next_min", edit_min, 30);

    // Commit 23:45:07 with ack delayed 3 cycles, buttons pulsed throughout.
    do_reset();
    set_cur(23, 45, 7);
    ack_delay = 3;
    step(1, 0, 0, 0);
    d0 = n_done;
    step(1, 0, 0, 0);
    check("t5_first_req", wr_req, 1);
    for (int i = 0; i < 3 * 5; i++)
      step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
    check("t5_done_once", n_done - d0, 1);
    check("t6_sec", edit_sec, 7);
    check("t6_min", edit_min, 45);
    check("t6_hr",  edit_hr,  23);
    check("t5_idle", edit_active, 0);

    // Reset in the middle of the minutes write.
    ack_delay = 2;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick();
    check("t1_in_wr_min", wr_addr, 8'h22);
    do_reset();
    check("t1_req_drop", wr_req, 0);
    check("t1_active",   edit_active, 0);

    // Randomized phase.
    for (int i = 0; i < 4000; i++) begin
      if (!m_com) ack_delay = $urandom_range(0, 3);
      set_cur($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
      reset = ($urandom_range(0, 299) == 0);
      step($urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      reset = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
